// File: rtl/clock_monitor.sv
// Clock monitor: periodically reads per-channel clock measurements from a
// counter block over an Avalon-MM master, compares each against an expected
// value with a tolerance, and raises sticky alarms plus a maskable interrupt.
// A small Avalon-MM slave exposes configuration, status and last readings.
module clock_monitor #(
    parameter int unsigned MEAS_BASE    = 4,
    parameter int unsigned SCAN_DEFAULT = 125000000,
    parameter int unsigned RESP_TIMEOUT = 255
) (
    input  logic        csi_clk_clk,
    input  logic        rsi_reset_reset,
    input  logic [4:0]  avs_ctrl_address,
    input  logic        avs_ctrl_read,
    input  logic        avs_ctrl_write,
    input  logic [31:0] avs_ctrl_writedata,
    output logic [31:0] avs_ctrl_readdata,
    output logic [3:0]  avm_meas_address,
    output logic        avm_meas_read,
    input  logic        avm_meas_waitrequest,
    input  logic [31:0] avm_meas_readdata,
    input  logic        avm_meas_readdatavalid,
    output logic [7:0]  coe_alarm,
    output logic        coe_irq
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        REQ   = 3'd2,
        RESP  = 3'd3,
        CHECK = 3'd4
    } state_t;

    localparam logic [31:0] ID_VALUE      = 32'hc10c3071;
    localparam logic [31:0] VERSION_VALUE = 32'h00010000;
    localparam logic [31:0] UNMAPPED      = 32'hdeadbeef;

    // Lowest enabled channel whose index is >= first; result is {found, index}.
    function automatic logic [3:0] find_channel(input logic [7:0] en, input logic [3:0] first);
        logic [3:0] res;
        res = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            if (en[i] && (4'(i) >= first)) begin
                res = {1'b1, 3'(i)};
            end
        end
        return res;
    endfunction

    // Magnitude of a - b, one bit wider so it never wraps.
    function automatic logic [32:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] r;
        if (a >= b) begin
            r = {1'b0, a} - {1'b0, b};
        end else begin
            r = {1'b0, b} - {1'b0, a};
        end
        return r;
    endfunction

    // Configuration and status registers
    logic        ctrl_enable;
    logic [7:0]  ch_en;
    logic [8:0]  status;
    logic [31:0] interval_reg;
    logic [31:0] tol_reg;
    logic [31:0] exp_mem [8];
    logic [31:0] last_mem [8];
    logic [8:0]  irq_mask;

    // Scan engine state
    state_t      state;
    state_t      state_next;
    logic [2:0]  ch;
    logic [2:0]  ch_next;
    logic [31:0] wait_cnt;
    logic [31:0] wait_cnt_next;
    logic [31:0] resp_cnt;
    logic [31:0] resp_cnt_next;
    logic        capture;
    logic        timeout_set;
    logic [7:0]  alarm_set;

    // Helpers shared by several FSM branches
    logic [31:0] interval_load;
    logic [3:0]  first_found;
    logic [3:0]  adv_found;
    logic [32:0] diff;
    state_t      adv_state;
    logic [2:0]  adv_ch;
    logic [31:0] adv_wait;

    // Slave decode
    logic        wr_ctrl;
    logic        wr_status;
    logic        wr_interval;
    logic        wr_tol;
    logic        wr_exp;
    logic        wr_mask;
    logic [2:0]  exp_idx;
    logic [2:0]  last_idx;
    logic [8:0]  status_clear;
    logic [31:0] rd_mux;

    assign interval_load = (interval_reg == 32'd0) ? 32'd1 : interval_reg;
    assign first_found   = find_channel(ch_en, 4'd0);
    assign adv_found     = find_channel(ch_en, {1'b0, ch} + 4'd1);
    assign diff          = abs_diff(last_mem[ch], exp_mem[ch]);

    assign exp_idx   = 3'(avs_ctrl_address - 5'd6);
    assign last_idx  = 3'(avs_ctrl_address - 5'd14);

    assign wr_ctrl     = avs_ctrl_write && (avs_ctrl_address == 5'd2);
    assign wr_status   = avs_ctrl_write && (avs_ctrl_address == 5'd3);
    assign wr_interval = avs_ctrl_write && (avs_ctrl_address == 5'd4);
    assign wr_tol      = avs_ctrl_write && (avs_ctrl_address == 5'd5);
    assign wr_exp      = avs_ctrl_write && (avs_ctrl_address >= 5'd6) && (avs_ctrl_address <= 5'd13);
    assign wr_mask     = avs_ctrl_write && (avs_ctrl_address == 5'd22);

    assign status_clear = wr_status ? avs_ctrl_writedata[8:0] : 9'd0;

    assign coe_alarm = status[7:0];

    // Destination once the current channel is finished (checked or timed out).
    // A cleared ENABLE stops the scan here so no new read is started.
    always_comb begin
        adv_state = state;
        adv_ch    = ch;
        adv_wait  = wait_cnt;
        if (!ctrl_enable) begin
            adv_state = IDLE;
        end else if (adv_found[3]) begin
            adv_state = REQ;
            adv_ch    = adv_found[2:0];
        end else begin
            adv_state = WAIT;
            adv_wait  = interval_load;
        end
    end

    // Scan FSM next-state logic and per-cycle event strobes.
    always_comb begin
        state_next    = state;
        ch_next       = ch;
        wait_cnt_next = wait_cnt;
        resp_cnt_next = resp_cnt;
        capture       = 1'b0;
        timeout_set   = 1'b0;
        alarm_set     = 8'd0;
        case (state)
            IDLE: begin
                if (ctrl_enable) begin
                    state_next    = WAIT;
                    wait_cnt_next = interval_load;
                end else begin
                    state_next = IDLE;
                end
            end
            WAIT: begin
                if (!ctrl_enable) begin
                    state_next = IDLE;
                end else if (wait_cnt <= 32'd1) begin
                    if (first_found[3]) begin
                        state_next = REQ;
                        ch_next    = first_found[2:0];
                    end else begin
                        wait_cnt_next = interval_load;
                    end
                end else begin
                    wait_cnt_next = wait_cnt - 32'd1;
                end
            end
            REQ: begin
                // The read stays presented until the slave accepts it.
                if (!avm_meas_waitrequest) begin
                    state_next    = RESP;
                    resp_cnt_next = 32'd1;
                end else begin
                    state_next = REQ;
                end
            end
            RESP: begin
                if (avm_meas_readdatavalid) begin
                    capture    = 1'b1;
                    state_next = CHECK;
                end else if (resp_cnt >= RESP_TIMEOUT) begin
                    timeout_set   = 1'b1;
                    state_next    = adv_state;
                    ch_next       = adv_ch;
                    wait_cnt_next = adv_wait;
                end else begin
                    resp_cnt_next = resp_cnt + 32'd1;
                end
            end
            CHECK: begin
                if (diff > {1'b0, tol_reg}) begin
                    alarm_set[ch] = 1'b1;
                end else begin
                    alarm_set = 8'd0;
                end
                state_next    = adv_state;
                ch_next       = adv_ch;
                wait_cnt_next = adv_wait;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Scan FSM state, counters and registered master-port outputs.
    always_ff @(posedge csi_clk_clk) begin
        if (rsi_reset_reset) begin
            state            <= IDLE;
            ch               <= 3'd0;
            wait_cnt         <= 32'd0;
            resp_cnt         <= 32'd0;
            avm_meas_read    <= 1'b0;
            avm_meas_address <= 4'd0;
        end else begin
            state         <= state_next;
            ch            <= ch_next;
            wait_cnt      <= wait_cnt_next;
            resp_cnt      <= resp_cnt_next;
            avm_meas_read <= (state_next == REQ);
            if (state_next == REQ) begin
                avm_meas_address <= 4'(MEAS_BASE) + {1'b0, ch_next};
            end
        end
    end

    // Writable configuration registers.
    always_ff @(posedge csi_clk_clk) begin
        if (rsi_reset_reset) begin
            ctrl_enable  <= 1'b0;
            ch_en        <= 8'd0;
            interval_reg <= SCAN_DEFAULT;
            tol_reg      <= 32'd0;
            irq_mask     <= 9'd0;
            for (int i = 0; i < 8; i++) begin
                exp_mem[i] <= 32'd0;
            end
        end else begin
            if (wr_ctrl) begin
                ctrl_enable <= avs_ctrl_writedata[0];
                ch_en       <= avs_ctrl_writedata[15:8];
            end
            if (wr_interval) begin
                interval_reg <= avs_ctrl_writedata;
            end
            if (wr_tol) begin
                tol_reg <= avs_ctrl_writedata;
            end
            if (wr_mask) begin
                irq_mask <= avs_ctrl_writedata[8:0];
            end
            if (wr_exp) begin
                exp_mem[exp_idx] <= avs_ctrl_writedata;
            end
        end
    end

    // Last accepted measurement per channel; timeouts leave it untouched.
    always_ff @(posedge csi_clk_clk) begin
        if (rsi_reset_reset) begin
            for (int i = 0; i < 8; i++) begin
                last_mem[i] <= 32'd0;
            end
        end else if (capture) begin
            last_mem[ch] <= avm_meas_readdata;
        end
    end

    // Sticky status: write-1-to-clear, a same-cycle set event wins over the clear.
    always_ff @(posedge csi_clk_clk) begin
        if (rsi_reset_reset) begin
            status <= 9'd0;
        end else begin
            status <= (status & ~status_clear) | {timeout_set, alarm_set};
        end
    end

    // Interrupt output, registered from the masked status.
    always_ff @(posedge csi_clk_clk) begin
        if (rsi_reset_reset) begin
            coe_irq <= 1'b0;
        end else begin
            coe_irq <= |(status & irq_mask);
        end
    end

    // Slave read multiplexer.
    always_comb begin
        rd_mux = UNMAPPED;
        case (avs_ctrl_address)
            5'd0:  rd_mux = ID_VALUE;
            5'd1:  rd_mux = VERSION_VALUE;
            5'd2:  rd_mux = {16'd0, ch_en, 7'd0, ctrl_enable};
            5'd3:  rd_mux = {23'd0, status};
            5'd4:  rd_mux = interval_reg;
            5'd5:  rd_mux = tol_reg;
            5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13:
                rd_mux = exp_mem[exp_idx];
            5'd14, 5'd15, 5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21:
                rd_mux = last_mem[last_idx];
            5'd22: rd_mux = {23'd0, irq_mask};
            default: rd_mux = UNMAPPED;
        endcase
    end

    // Slave readdata register, one cycle after the read strobe.
    always_ff @(posedge csi_clk_clk) begin
        if (rsi_reset_reset) begin
            avs_ctrl_readdata <= 32'd0;
        end else if (avs_ctrl_read) begin
            avs_ctrl_readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_clock_monitor.sv
// Self-checking bench for clock_monitor: register table, directed scan
// scenarios and randomized scans compared against a simple arithmetic model.
module tb_clock_monitor;

    localparam int unsigned MEAS_BASE    = 4;
    localparam int unsigned RESP_TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  avs_address = 5'd0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = 32'd0;
    logic [31:0] avs_readdata;
    logic [3:0]  avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;
    logic [7:0]  alarm;
    logic        irq;

    clock_monitor #(
        .MEAS_BASE(MEAS_BASE),
        .SCAN_DEFAULT(125000000),
        .RESP_TIMEOUT(RESP_TIMEOUT)
    ) dut (
        .csi_clk_clk(clk),
        .rsi_reset_reset(rst),
        .avs_ctrl_address(avs_address),
        .avs_ctrl_read(avs_read),
        .avs_ctrl_write(avs_write),
        .avs_ctrl_writedata(avs_writedata),
        .avs_ctrl_readdata(avs_readdata),
        .avm_meas_address(avm_address),
        .avm_meas_read(avm_read),
        .avm_meas_waitrequest(avm_waitrequest),
        .avm_meas_readdata(avm_readdata),
        .avm_meas_readdatavalid(avm_readdatavalid),
        .coe_alarm(alarm),
        .coe_irq(irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Measurement slave model state
    logic [31:0] mem [16];
    int          wait_knob = 0;
    int          lat_knob = 0;
    bit          no_resp = 1'b0;
    int          acc_q[$];
    int          len_q[$];
    bit          unstable = 1'b0;
    bit          presenting = 1'b0;
    int          wait_left = 0;
    int          cur_len = 0;
    logic [3:0]  cur_addr = 4'd0;
    bit          pend = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_data = 32'd0;

    // Counter-block responder: inserts wait states, returns data after a latency.
    initial begin
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b0;
        avm_readdata      = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            avm_readdatavalid = 1'b0;
            if (pend) begin
                if (pend_cnt == 0) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata      = pend_data;
                    pend              = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end
            if (avm_read) begin
                if (!presenting) begin
                    presenting = 1'b1;
                    wait_left  = wait_knob;
                    cur_len    = 0;
                    cur_addr   = avm_address;
                end
                cur_len++;
                if (avm_address != cur_addr) unstable = 1'b1;
                if (wait_left > 0) begin
                    avm_waitrequest = 1'b1;
                    wait_left--;
                end else begin
                    avm_waitrequest = 1'b0;
                    presenting      = 1'b0;
                    acc_q.push_back(int'(cur_addr));
                    len_q.push_back(cur_len);
                    if (!no_resp) begin
                        pend      = 1'b1;
                        pend_cnt  = lat_knob;
                        pend_data = mem[cur_addr];
                    end
                end
            end else begin
                if (presenting) unstable = 1'b1;
                presenting      = 1'b0;
                avm_waitrequest = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic ctrl_write(input logic [4:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        avs_write = 1'b1;
        avs_address = a;
        avs_writedata = d;
        @(posedge clk);
        #1;
        avs_write = 1'b0;
    endtask

    task automatic ctrl_read(input logic [4:0] a, output logic [31:0] d);
        @(posedge clk);
        #1;
        avs_read = 1'b1;
        avs_address = a;
        @(posedge clk);
        #1;
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    task automatic read_check(input string name, input logic [4:0] a, input logic [31:0] exp);
        logic [31:0] d;
        ctrl_read(a, d);
        check(name, d, exp);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        avs_read = 1'b0;
        avs_write = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        unstable = 1'b0;
        wait_knob = 0;
        lat_knob = 0;
        no_resp = 1'b0;
        acc_q.delete();
        len_q.delete();
    endtask

    task automatic wait_acc(input string name, input int n, input int budget);
        for (int i = 0; i < budget && acc_q.size() < n; i++) @(negedge clk);
        check(name, 32'(acc_q.size() >= n), 32'd1);
    endtask

    typedef struct {
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t tab[$];

    initial begin
        logic [31:0] d;
        logic [31:0] expv [8];
        logic [31:0] datv [8];
        logic [7:0]  en;
        logic [31:0] tol;
        logic [7:0]  exp_alarm;
        int          exp_addr[$];
        longint      a, b, df;

        for (int i = 0; i < 16; i++) mem[i] = 32'd0;

        // Reset state and register map table
        tab.push_back('{1'b0, 5'd0,  32'd0, 32'hc10c3071});
        tab.push_back('{1'b0, 5'd1,  32'd0, 32'h00010000});
        tab.push_back('{1'b0, 5'd2,  32'd0, 32'd0});
        tab.push_back('{1'b0, 5'd3,  32'd0, 32'd0});
        tab.push_back('{1'b0, 5'd4,  32'd0, 32'd125000000});
        tab.push_back('{1'b0, 5'd5,  32'd0, 32'd0});
        tab.push_back('{1'b0, 5'd6,  32'd0, 32'd0});
        tab.push_back('{1'b0, 5'd13, 32'd0, 32'd0});
        tab.push_back('{1'b0, 5'd14, 32'd0, 32'd0});
        tab.push_back('{1'b0, 5'd21, 32'd0, 32'd0});
        tab.push_back('{1'b0, 5'd22, 32'd0, 32'd0});
        tab.push_back('{1'b0, 5'd23, 32'd0, 32'hdeadbeef});
        tab.push_back('{1'b0, 5'd31, 32'd0, 32'hdeadbeef});
        tab.push_back('{1'b1, 5'd2,  32'hffffff00, 32'h0000ff00});
        tab.push_back('{1'b1, 5'd2,  32'h00000000, 32'h00000000});
        tab.push_back('{1'b1, 5'd4,  32'h00000000, 32'h00000000});
        tab.push_back('{1'b1, 5'd4,  32'h00001234, 32'h00001234});
        tab.push_back('{1'b1, 5'd5,  32'ha5a5a5a5, 32'ha5a5a5a5});
        tab.push_back('{1'b1, 5'd9,  32'h12345678, 32'h12345678});
        tab.push_back('{1'b1, 5'd22, 32'hffffffff, 32'h000001ff});
        tab.push_back('{1'b1, 5'd17, 32'h00000055, 32'h00000000});
        tab.push_back('{1'b1, 5'd0,  32'h00000001, 32'hc10c3071});
        tab.push_back('{1'b1, 5'd3,  32'hffffffff, 32'h00000000});

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_avm_read", 32'(avm_read), 32'd0);
        check("rst_avm_addr", 32'(avm_address), 32'd0);
        check("rst_alarm", 32'(alarm), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_readdata", avs_readdata, 32'd0);

        for (int i = 0; i < tab.size(); i++) begin
            if (tab[i].wr) ctrl_write(tab[i].addr, tab[i].wdata);
            ctrl_read(tab[i].addr, d);
            check($sformatf("reg_vec%0d_a%0d", i, tab[i].addr), d, tab[i].exp);
        end

        // Basic scan with wait states on the master port
        do_reset();
        mem[4] = 32'd100;
        mem[6] = 32'd200;
        wait_knob = 3;
        ctrl_write(5'd4, 32'd10);
        ctrl_write(5'd6, 32'd100);
        ctrl_write(5'd8, 32'd150);
        ctrl_write(5'd5, 32'd10);
        ctrl_write(5'd2, 32'h00000501);
        wait_acc("scan_reads", 2, 200);
        repeat (6) @(negedge clk);
        check("scan_addr0", 32'(acc_q[0]), 32'd4);
        check("scan_addr1", 32'(acc_q[1]), 32'd6);
        check("hold_len0", 32'(len_q[0]), 32'd4);
        check("hold_stable", 32'(unstable), 32'd0);
        read_check("scan_last0", 5'd14, 32'd100);
        read_check("scan_last2", 5'd16, 32'd200);
        read_check("scan_status", 5'd3, 32'h004);
        check("scan_alarm", 32'(alarm), 32'h04);

        // No-wrap difference and tolerance boundaries, then write-1-to-clear
        do_reset();
        mem[4] = 32'h00000010;
        mem[5] = 32'h00000010;
        mem[6] = 32'h00000120;
        ctrl_write(5'd4, 32'd1000);
        ctrl_write(5'd6, 32'hfffffff0);
        ctrl_write(5'd7, 32'h00000030);
        ctrl_write(5'd8, 32'h00000100);
        ctrl_write(5'd5, 32'h00000020);
        ctrl_write(5'd2, 32'h00000701);
        wait_acc("wrap_reads", 3, 1200);
        repeat (6) @(negedge clk);
        read_check("wrap_status", 5'd3, 32'h001);
        ctrl_write(5'd2, 32'h00000000);
        repeat (5) @(negedge clk);
        ctrl_write(5'd3, 32'h00000001);
        read_check("w1c_status", 5'd3, 32'h000);

        // Alarm set in the same cycle as its clear; irq follows
        do_reset();
        mem[4] = 32'd500;
        lat_knob = 2;
        ctrl_write(5'd4, 32'd1000);
        ctrl_write(5'd22, 32'h001);
        ctrl_write(5'd2, 32'h00000101);
        for (int i = 0; i < 1300 && !avm_readdatavalid; i++) @(negedge clk);
        check("race_valid_seen", 32'(avm_readdatavalid), 32'd1);
        @(posedge clk);
        #1;
        avs_write = 1'b1;
        avs_address = 5'd3;
        avs_writedata = 32'h001;
        @(posedge clk);
        #1;
        avs_write = 1'b0;
        check("race_alarm", 32'(alarm), 32'h01);
        @(posedge clk);
        #1;
        check("race_irq", 32'(irq), 32'd1);

        // Response timeout and continuation to the next channel
        do_reset();
        no_resp = 1'b1;
        ctrl_write(5'd4, 32'd5);
        ctrl_write(5'd2, 32'h00000301);
        for (int i = 0; i < 100 && acc_q.size() < 1; i++) @(negedge clk);
        check("tmo_first_read", 32'(acc_q.size()), 32'd1);
        avs_read = 1'b1;
        avs_address = 5'd3;
        @(posedge clk);
        repeat (RESP_TIMEOUT) @(posedge clk);
        #1;
        check("tmo_before", 32'(avs_readdata[8]), 32'd0);
        @(posedge clk);
        #1;
        check("tmo_after", 32'(avs_readdata[8]), 32'd1);
        avs_read = 1'b0;
        wait_acc("tmo_next_read", 2, 50);
        check("tmo_next_addr", 32'(acc_q[1]), 32'd5);
        read_check("tmo_last0", 5'd14, 32'd0);

        // ENABLE cleared while a response is pending
        do_reset();
        mem[4] = 32'd77;
        lat_knob = 20;
        ctrl_write(5'd4, 32'd3);
        ctrl_write(5'd5, 32'd5);
        ctrl_write(5'd2, 32'h00000301);
        wait_acc("dis_read", 1, 100);
        ctrl_write(5'd2, 32'h00000300);
        repeat (60) @(negedge clk);
        check("dis_reads", 32'(acc_q.size()), 32'd1);
        check("dis_read_low", 32'(avm_read), 32'd0);
        read_check("dis_last0", 5'd14, 32'd77);
        read_check("dis_status", 5'd3, 32'h001);

        // Reset mid-transaction, stray readdatavalid afterwards
        do_reset();
        mem[4] = 32'd999;
        ctrl_write(5'd4, 32'd2);
        lat_knob = 10;
        ctrl_write(5'd2, 32'h00000101);
        wait_acc("mid_read", 1, 100);
        lat_knob = 10;
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_read_low", 32'(avm_read), 32'd0);
        repeat (30) @(negedge clk);
        unstable = 1'b0;
        check("mid_reads", 32'(acc_q.size()), 32'd1);
        read_check("mid_last0", 5'd14, 32'd0);
        read_check("mid_status", 5'd3, 32'd0);

        // Randomized scans against the arithmetic model
        for (int it = 0; it < 6; it++) begin
            do_reset();
            en = 8'($urandom_range(1, 255));
            tol = 32'($urandom_range(0, 40));
            wait_knob = int'($urandom_range(0, 2));
            lat_knob = int'($urandom_range(0, 3));
            exp_alarm = 8'd0;
            exp_addr.delete();
            for (int c = 0; c < 8; c++) begin
                expv[c] = (it % 2 == 1) ? 32'($urandom_range(0, 20)) : 32'($urandom);
                datv[c] = expv[c] + 32'(int'($urandom_range(0, 100)) - 50);
                mem[MEAS_BASE + c] = datv[c];
                ctrl_write(5'(6 + c), expv[c]);
                if (en[c]) begin
                    exp_addr.push_back(int'(MEAS_BASE) + c);
                    a = datv[c];
                    b = expv[c];
                    df = (a > b) ? (a - b) : (b - a);
                    if (df > longint'(tol)) exp_alarm[c] = 1'b1;
                end
            end
            ctrl_write(5'd5, tol);
            ctrl_write(5'd4, (it % 2 == 1) ? 32'd0 : 32'd1000);
            ctrl_write(5'd2, {16'd0, en, 8'h01});
            wait_acc($sformatf("rnd%0d_reads", it), exp_addr.size(), 2000);
            repeat (10) @(negedge clk);
            for (int k = 0; k < exp_addr.size(); k++) begin
                check($sformatf("rnd%0d_addr%0d", it, k),
                      (k < acc_q.size()) ? 32'(acc_q[k]) : 32'hffffffff, 32'(exp_addr[k]));
            end
            check($sformatf("rnd%0d_alarm", it), 32'(alarm), 32'(exp_alarm));
            for (int c = 0; c < 8; c++) begin
                if (en[c]) read_check($sformatf("rnd%0d_last%0d", it, c), 5'(14 + c), datv[c]);
            end
            check($sformatf("rnd%0d_stable", it), 32'(unstable), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
